axis_pattern_gen: RTL and testbench

Packet-based AXI4-Stream test-pattern source that drives the input stream of the AXI-Stream FIFO demo core (`i_axis_in_*`). Once started, it emits a configured number of packets of configured length with an incrementing data pattern. It marks the first beat with `tuser` and the last with `tlast`, and honours downstream backpressure. It lets the FIFO path be exercised on hardware and in simulation without an external traffic source.

---
 rtl/axis_pattern_gen_pkg.sv | 11 +
 rtl/axis_pattern_gen.sv | 173 +++++++++++++++++
 tb/tb_axis_pattern_gen.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pattern_gen_pkg.sv
// Shared stream-demo definitions: pattern generator FSM encodings.
package axis_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } pg_state_e;

endpackage

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream packet test-pattern source: incrementing data, tuser on first
// beat, tlast on last beat, configurable gap, graceful stop, backpressure aware.
module axis_pattern_gen
  import axis_pattern_gen_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int COUNT_WIDTH     = 16,
  parameter int GAP_WIDTH       = 8
) (
  input  logic                       i_axis_clk,
  input  logic                       i_axis_rst,
  input  logic                       i_start,
  input  logic                       i_stop,
  input  logic [LEN_WIDTH-1:0]       i_packet_len,
  input  logic [COUNT_WIDTH-1:0]     i_packet_count,
  input  logic [GAP_WIDTH-1:0]       i_gap,
  input  logic [AXIS_DATA_WIDTH-1:0] i_seed,
  output logic                       o_busy,
  output logic                       o_done_stb,
  output logic [COUNT_WIDTH-1:0]     o_packets_sent,
  output logic                       o_axis_out_tuser,
  output logic                       o_axis_out_tvalid,
  input  logic                       i_axis_out_tready,
  output logic                       o_axis_out_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] o_axis_out_tdata
);

  pg_state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]       len_q, len_d, beat_q, beat_d, len_eff;
  logic [COUNT_WIDTH-1:0]     count_q, count_d, sent_q, sent_d, sent_inc;
  logic [GAP_WIDTH-1:0]       gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic                       stop_q, stop_d;
  logic                       busy_q, busy_d, done_q, done_d;
  logic                       tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
  logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                       last_pkt;

  assign len_eff  = (i_packet_len == '0) ? LEN_WIDTH'(1) : i_packet_len;
  assign sent_inc = sent_q + COUNT_WIDTH'(1);
  assign last_pkt = (count_q != '0) && (sent_inc == count_q);

  // Every output is a register; next values are computed here so tready
  // never reaches an output combinationally.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    beat_d    = beat_q;
    sent_d    = sent_q;
    stop_d    = stop_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tvalid_d  = tvalid_q;
    tuser_d   = tuser_q;
    tlast_d   = tlast_q;
    tdata_d   = tdata_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d  = ST_SEND;
          len_d    = len_eff;
          count_d  = i_packet_count;
          gap_d    = i_gap;
          tdata_d  = i_seed;
          tvalid_d = 1'b1;
          tuser_d  = 1'b1;
          tlast_d  = (len_eff == LEN_WIDTH'(1));
          beat_d   = '0;
          sent_d   = '0;
          busy_d   = 1'b1;
          stop_d   = 1'b0;
        end
      end
      ST_SEND: begin
        if (i_stop) stop_d = 1'b1;
        if (tvalid_q && i_axis_out_tready) begin
          tdata_d = tdata_q + AXIS_DATA_WIDTH'(1);
          if (tlast_q) begin
            sent_d = sent_inc;
            beat_d = '0;
            if (last_pkt || stop_q || i_stop) begin
              state_d  = ST_DONE;
              tvalid_d = 1'b0;
              tuser_d  = 1'b0;
              tlast_d  = 1'b0;
              done_d   = 1'b1;
              busy_d   = 1'b0;
            end else if (gap_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
              tvalid_d  = 1'b0;
              tuser_d   = 1'b0;
              tlast_d   = 1'b0;
            end else begin
              tuser_d = 1'b1;
              tlast_d = (len_q == LEN_WIDTH'(1));
            end
          end else begin
            beat_d  = beat_q + LEN_WIDTH'(1);
            tuser_d = 1'b0;
            tlast_d = ((beat_q + LEN_WIDTH'(1)) == (len_q - LEN_WIDTH'(1)));
          end
        end
      end
      ST_GAP: begin
        if (i_stop || stop_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (gap_cnt_q <= GAP_WIDTH'(1)) begin
          state_d  = ST_SEND;
          tvalid_d = 1'b1;
          tuser_d  = 1'b1;
          tlast_d  = (len_q == LEN_WIDTH'(1));
          beat_d   = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        stop_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_axis_clk or negedge i_axis_rst) begin
    if (!i_axis_rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      count_q   <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      beat_q    <= '0;
      sent_q    <= '0;
      stop_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tvalid_q  <= 1'b0;
      tuser_q   <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      count_q   <= count_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      beat_q    <= beat_d;
      sent_q    <= sent_d;
      stop_q    <= stop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tvalid_q  <= tvalid_d;
      tuser_q   <= tuser_d;
      tlast_q   <= tlast_d;
      tdata_q   <= tdata_d;
    end
  end

  assign o_busy            = busy_q;
  assign o_done_stb        = done_q;
  assign o_packets_sent    = sent_q;
  assign o_axis_out_tvalid = tvalid_q;
  assign o_axis_out_tuser  = tuser_q;
  assign o_axis_out_tlast  = tlast_q;
  assign o_axis_out_tdata  = tdata_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Directed bench for axis_pattern_gen: cycle table plus hand-written corner sequences.
module tb_axis_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, tready;
  logic [15:0] plen, pcount;
  logic [7:0]  gap;
  logic [31:0] seed;
  logic        busy, done, tuser, tvalid, tlast;
  logic [15:0] sent;
  logic [31:0] tdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_pattern_gen dut (
    .i_axis_clk        (clk),
    .i_axis_rst        (rst_n),
    .i_start           (start),
    .i_stop            (stop),
    .i_packet_len      (plen),
    .i_packet_count    (pcount),
    .i_gap             (gap),
    .i_seed            (seed),
    .o_busy            (busy),
    .o_done_stb        (done),
    .o_packets_sent    (sent),
    .o_axis_out_tuser  (tuser),
    .o_axis_out_tvalid (tvalid),
    .i_axis_out_tready (tready),
    .o_axis_out_tlast  (tlast),
    .o_axis_out_tdata  (tdata)
  );

  typedef struct {
    bit          st;
    logic [15:0] len;
    logic [15:0] cnt;
    logic [7:0]  gp;
    logic [31:0] sd;
    bit          rdy;
    bit          vld;
    logic [31:0] data;
    bit          usr;
    bit          lst;
    bit          dn;
    bit          bsy;
    logic [15:0] snt;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk_start(input logic [15:0] l, input logic [15:0] c,
                                    input logic [7:0] g, input logic [31:0] s,
                                    input logic [15:0] snt);
    row_t r;
    r = '{st:1'b1, len:l, cnt:c, gp:g, sd:s, rdy:1'b1, vld:1'b0, data:32'd0,
          usr:1'b0, lst:1'b0, dn:1'b0, bsy:1'b0, snt:snt};
    return r;
  endfunction

  function automatic row_t mk(input bit rdy, input bit vld, input logic [31:0] d,
                              input bit u, input bit l, input bit dn, input bit b,
                              input logic [15:0] snt);
    row_t r;
    r = '{st:1'b0, len:16'd0, cnt:16'd0, gp:8'd0, sd:32'd0, rdy:rdy, vld:vld, data:d,
          usr:u, lst:l, dn:dn, bsy:b, snt:snt};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cfg(input logic [15:0] l, input logic [15:0] c,
                     input logic [7:0] g, input logic [31:0] s);
    plen = l; pcount = c; gap = g; seed = s;
  endtask

  logic [63:0] act, exp;
  int nb, derr, vcount;
  bit got_done;

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; tready = 1'b0;
    cfg(16'd0, 16'd0, 8'd0, 32'd0);

    // Basic run: len 4, count 2, gap 0, seed 0x10
    tbl.push_back(mk_start(16'd4, 16'd2, 8'd0, 32'h10, 16'd0));
    tbl.push_back(mk(1, 1, 32'h10, 1, 0, 0, 1, 16'd0));
    tbl.push_back(mk(1, 1, 32'h11, 0, 0, 0, 1, 16'd0));
    tbl.push_back(mk(1, 1, 32'h12, 0, 0, 0, 1, 16'd0));
    tbl.push_back(mk(1, 1, 32'h13, 0, 1, 0, 1, 16'd0));
    tbl.push_back(mk(1, 1, 32'h14, 1, 0, 0, 1, 16'd1));
    tbl.push_back(mk(1, 1, 32'h15, 0, 0, 0, 1, 16'd1));
    tbl.push_back(mk(1, 1, 32'h16, 0, 0, 0, 1, 16'd1));
    tbl.push_back(mk(1, 1, 32'h17, 0, 1, 0, 1, 16'd1));
    tbl.push_back(mk(1, 0, 32'h0,  0, 0, 1, 0, 16'd2));
    tbl.push_back(mk(1, 0, 32'h0,  0, 0, 0, 0, 16'd2));
    // Backpressure: len 3, count 1, tready 1,0,0,1,0,1
    tbl.push_back(mk_start(16'd3, 16'd1, 8'd0, 32'h100, 16'd2));
    tbl.push_back(mk(1, 1, 32'h100, 1, 0, 0, 1, 16'd0));
    tbl.push_back(mk(0, 1, 32'h101, 0, 0, 0, 1, 16'd0));
    tbl.push_back(mk(0, 1, 32'h101, 0, 0, 0, 1, 16'd0));
    tbl.push_back(mk(1, 1, 32'h101, 0, 0, 0, 1, 16'd0));
    tbl.push_back(mk(0, 1, 32'h102, 0, 1, 0, 1, 16'd0));
    tbl.push_back(mk(1, 1, 32'h102, 0, 1, 0, 1, 16'd0));
    tbl.push_back(mk(1, 0, 32'h0,   0, 0, 1, 0, 16'd1));
    tbl.push_back(mk(1, 0, 32'h0,   0, 0, 0, 0, 16'd1));
    // len 0 treated as 1, gap 2, data wraps through zero
    tbl.push_back(mk_start(16'd0, 16'd3, 8'd2, 32'hFFFF_FFFE, 16'd1));
    tbl.push_back(mk(1, 1, 32'hFFFF_FFFE, 1, 1, 0, 1, 16'd0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 0, 1, 16'd1));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 0, 1, 16'd1));
    tbl.push_back(mk(1, 1, 32'hFFFF_FFFF, 1, 1, 0, 1, 16'd1));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 0, 1, 16'd2));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 0, 1, 16'd2));
    tbl.push_back(mk(1, 1, 32'h0000_0000, 1, 1, 0, 1, 16'd2));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 1, 0, 16'd3));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 0, 0, 16'd3));

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", {11'd0, tvalid, tdata, tuser, tlast, done, busy, sent}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      act = {11'd0, tvalid, (tbl[i].vld ? {tdata, tuser, tlast} : 34'd0), done, busy, sent};
      exp = {11'd0, tbl[i].vld, (tbl[i].vld ? {tbl[i].data, tbl[i].usr, tbl[i].lst} : 34'd0),
             tbl[i].dn, tbl[i].bsy, tbl[i].snt};
      check($sformatf("row%0d", i), act, exp);
      start  = tbl[i].st;
      tready = tbl[i].rdy;
      if (tbl[i].st) cfg(tbl[i].len, tbl[i].cnt, tbl[i].gp, tbl[i].sd);
    end

    // Stop in IDLE and start during SEND must both be ignored
    @(negedge clk);
    start = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; start = 1'b1; tready = 1'b1;
    cfg(16'd2, 16'd2, 8'd0, 32'h50);
    nb = 0; got_done = 1'b0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      @(negedge clk);
      if (tvalid) begin
        check($sformatf("ign_beat%0d", nb), {29'd0, tdata, tuser, tlast, 1'b1},
              {29'd0, 32'h50 + 32'(nb), (nb % 2 == 0), (nb % 2 == 1), 1'b1});
        nb++;
      end
      if (done) got_done = 1'b1;
      start = (c == 0);
      if (c == 0) cfg(16'd7, 16'd9, 8'd3, 32'h99);
    end
    start = 1'b0;
    check("ign_beats", 64'(nb), 64'd4);
    check("ign_done", 64'(got_done), 64'd1);
    check("ign_sent", 64'(sent), 64'd2);

    // Continuous mode, stop during beat 2 of packet 7
    @(negedge clk);
    cfg(16'd5, 16'd0, 8'd0, 32'd0);
    start = 1'b1; tready = 1'b1;
    nb = 0; derr = 0; got_done = 1'b0;
    for (int c = 0; c < 60 && !got_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (tvalid) begin
        if (tdata != 32'(nb)) derr++;
        nb++;
      end
      if (done) got_done = 1'b1;
      stop = tvalid && (tdata == 32'd31);
    end
    stop = 1'b0;
    check("cont_done", 64'(got_done), 64'd1);
    check("cont_beats", 64'(nb), 64'd35);
    check("cont_data_errs", 64'(derr), 64'd0);
    check("cont_sent", 64'(sent), 64'd7);
    check("cont_busy_at_done", 64'(busy), 64'd0);
    vcount = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (tvalid) vcount++;
    end
    check("cont_no_more_valid", 64'(vcount), 64'd0);

    // Asynchronous reset in the middle of a packet
    cfg(16'd4, 16'd1, 8'd0, 32'hA0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_beat0", {31'd0, tvalid, tdata}, {31'd0, 1'b1, 32'hA0});
    @(negedge clk);
    check("rst_beat1", {31'd0, tvalid, tdata}, {31'd0, 1'b1, 32'hA1});
    #2 rst_n = 1'b0;
    #1 check("rst_async_zero", {11'd0, tvalid, tdata, tuser, tlast, done, busy, sent}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_restart", {30'd0, tvalid, tuser, tdata}, {30'd0, 1'b1, 1'b1, 32'hA0});
    got_done = 1'b0;
    for (int c = 0; c < 10 && !got_done; c++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    check("rst_run_done", {47'd0, got_done, sent}, {47'd0, 1'b1, 16'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
